// File: rtl/rvc_pkg.sv
// Shared definitions for the RVC (compressed RISC-V) quadrant-1 decode unit.
// Holds the decoded op-class enum, quadrant constants and the mapping of
// 3-bit compressed register fields onto the full register index space.
package rvc_pkg;

   typedef enum logic [4:0] {
      OP_NOP      = 5'd0,
      OP_ADDI     = 5'd1,
      OP_JAL      = 5'd2,
      OP_LI       = 5'd3,
      OP_ADDI16SP = 5'd4,
      OP_LUI      = 5'd5,
      OP_SRLI     = 5'd6,
      OP_SRAI     = 5'd7,
      OP_ANDI     = 5'd8,
      OP_SUB      = 5'd9,
      OP_XOR      = 5'd10,
      OP_OR       = 5'd11,
      OP_AND      = 5'd12,
      OP_J        = 5'd13,
      OP_BEQZ     = 5'd14,
      OP_BNEZ     = 5'd15,
      OP_ILLEGAL  = 5'd16,
      OP_UNSUP    = 5'd17
   } op_e;

   localparam logic [1:0] QUAD0 = 2'b00;
   localparam logic [1:0] QUAD1 = 2'b01;
   localparam logic [1:0] QUAD2 = 2'b10;
   localparam logic [1:0] QUAD3 = 2'b11;

   // rd'/rs' fields only reach x8..x15
   function automatic logic [4:0] creg(input logic [2:0] f);
      return {2'b01, f};
   endfunction

endpackage

// File: rtl/rvc_q1_decode.sv
// Combinational decoder for 16-bit compressed instructions.
// Ports:
//   opcode_i  : compressed instruction
//   op_o      : op class
//   rd_o      : destination register index
//   nrd_o     : number of register reads needed (0..2)
//   rs1_o     : first register to read, rs2_o : second register to read
//   imm_o     : CI immediate (sign-extended) or shamt (zero-extended)
//   illegal_o : illegal or unsupported instruction
module rvc_q1_decode
   import rvc_pkg::*;
(
   input  logic [15:0] opcode_i,
   output op_e         op_o,
   output logic [4:0]  rd_o,
   output logic [1:0]  nrd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [11:0] imm_o,
   output logic        illegal_o
);

   logic [2:0]  f3;
   logic [4:0]  rfull;
   logic [4:0]  rc1;
   logic [4:0]  rc2;
   logic [11:0] ci_imm;
   logic [11:0] shamt;

   assign f3     = opcode_i[15:13];
   assign rfull  = opcode_i[11:7];
   assign rc1    = creg(opcode_i[9:7]);
   assign rc2    = creg(opcode_i[4:2]);
   assign ci_imm = {{6{opcode_i[12]}}, opcode_i[12], opcode_i[6:2]};
   assign shamt  = {6'b0, opcode_i[12], opcode_i[6:2]};

   always_comb begin
      op_o      = OP_ILLEGAL;
      rd_o      = '0;
      nrd_o     = 2'd0;
      rs1_o     = '0;
      rs2_o     = '0;
      imm_o     = '0;
      illegal_o = 1'b1;
      if (opcode_i[1:0] == QUAD1) begin
         illegal_o = 1'b0;
         case (f3)
            3'b000: begin
               if (opcode_i == 16'h0001) begin
                  op_o = OP_NOP;
               end else begin
                  op_o  = OP_ADDI;
                  rd_o  = rfull;
                  rs1_o = rfull;
                  nrd_o = 2'd1;
                  imm_o = ci_imm;
               end
            end
            3'b001: begin
               op_o = OP_JAL;
               rd_o = 5'd1;   // link register
            end
            3'b010: begin
               op_o  = OP_LI;
               rd_o  = rfull;
               imm_o = ci_imm;
            end
            3'b011: begin
               if (rfull == 5'd2) begin
                  op_o  = OP_ADDI16SP;
                  rd_o  = 5'd2;
                  rs1_o = 5'd2;
                  nrd_o = 2'd1;
               end else begin
                  op_o = OP_LUI;
                  rd_o = rfull;
               end
               imm_o = ci_imm;
            end
            3'b100: begin
               rd_o  = rc1;
               rs1_o = rc1;
               nrd_o = 2'd1;
               case (opcode_i[11:10])
                  2'b00: begin op_o = OP_SRLI; imm_o = shamt;  end
                  2'b01: begin op_o = OP_SRAI; imm_o = shamt;  end
                  2'b10: begin op_o = OP_ANDI; imm_o = ci_imm; end
                  default: begin
                     if (opcode_i[12]) begin
                        // reserved/RV64-only register-register encodings
                        op_o      = OP_ILLEGAL;
                        illegal_o = 1'b1;
                        rd_o      = '0;
                        rs1_o     = '0;
                        nrd_o     = 2'd0;
                     end else begin
                        nrd_o = 2'd2;
                        rs2_o = rc2;
                        case (opcode_i[6:5])
                           2'b00:   op_o = OP_SUB;
                           2'b01:   op_o = OP_XOR;
                           2'b10:   op_o = OP_OR;
                           default: op_o = OP_AND;
                        endcase
                     end
                  end
               endcase
            end
            3'b101: op_o = OP_J;
            3'b110: begin
               op_o  = OP_BEQZ;
               rs1_o = rc1;
               nrd_o = 2'd1;
            end
            default: begin
               op_o  = OP_BNEZ;
               rs1_o = rc1;
               nrd_o = 2'd1;
            end
         endcase
      end else if (opcode_i[1:0] != QUAD3) begin
         op_o = OP_UNSUP;
      end
   end

endmodule

// File: rtl/rvc_decode_unit.sv
// Compressed-instruction decode unit: accepts a 16-bit RVC opcode, decodes it,
// fetches up to two source operands from a banked register file and presents
// the decoded result behind a valid/ready handshake.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   opcode, in_valid/ready: instruction input handshake
//   req_data, addr,
//   chip_sel              : register-file read request and location
//   cu_done, cu_dataout   : read completion and data
//   out_valid/out_ready   : result handshake
//   out_op, out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_err : result
module rvc_decode_unit
   import rvc_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int REGS_PER_BANK = 8,
   parameter int NUM_BANKS     = 4,
   parameter int TIMEOUT       = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [15:0]                  opcode,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         req_data,
   output logic [$clog2(REGS_PER_BANK)-1:0] addr,
   output logic [$clog2(NUM_BANKS)-1:0] chip_sel,
   input  logic                         cu_done,
   input  logic [DATA_W-1:0]            cu_dataout,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [4:0]                   out_op,
   output logic [4:0]                   out_rd,
   output logic [DATA_W-1:0]            out_rs1,
   output logic [DATA_W-1:0]            out_rs2,
   output logic [11:0]                  out_imm,
   output logic                         out_illegal,
   output logic                         out_err
);

   localparam int AW  = $clog2(REGS_PER_BANK);
   localparam int CSW = $clog2(NUM_BANKS);
   localparam int CW  = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, RD1, RD2, OUT} state_e;

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   logic [1:0]  nrd_q, nrd_d;
   logic [4:0]  ra1_q, ra1_d;
   logic [4:0]  ra2_q, ra2_d;
   logic [11:0] imm_q, imm_d;
   logic        ill_q, ill_d;
   logic        err_q, err_d;
   logic [DATA_W-1:0] rs1_q, rs1_d;
   logic [DATA_W-1:0] rs2_q, rs2_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   op_e         dec_op;
   logic [4:0]  dec_rd, dec_ra1, dec_ra2;
   logic [1:0]  dec_nrd;
   logic [11:0] dec_imm;
   logic        dec_ill;
   logic [4:0]  rd_idx;

   rvc_q1_decode u_dec (
      .opcode_i  (opcode),
      .op_o      (dec_op),
      .rd_o      (dec_rd),
      .nrd_o     (dec_nrd),
      .rs1_o     (dec_ra1),
      .rs2_o     (dec_ra2),
      .imm_o     (dec_imm),
      .illegal_o (dec_ill)
   );

   // Request and location fall straight out of the state, so an async reset
   // drops them in the same instant.
   assign in_ready  = (state_q == IDLE);
   assign req_data  = (state_q == RD1) || (state_q == RD2);
   assign out_valid = (state_q == OUT);
   assign rd_idx    = (state_q == RD2) ? ra2_q : ra1_q;
   assign addr      = req_data ? rd_idx[AW-1:0] : '0;
   assign chip_sel  = req_data ? CSW'(rd_idx >> AW) : '0;

   assign out_op      = op_q;
   assign out_rd      = rd_q;
   assign out_rs1     = rs1_q;
   assign out_rs2     = rs2_q;
   assign out_imm     = imm_q;
   assign out_illegal = ill_q;
   assign out_err     = err_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      nrd_d   = nrd_q;
      ra1_d   = ra1_q;
      ra2_d   = ra2_q;
      imm_d   = imm_q;
      ill_d   = ill_q;
      err_d   = err_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = dec_op;
               rd_d    = dec_rd;
               nrd_d   = dec_nrd;
               ra1_d   = dec_ra1;
               ra2_d   = dec_ra2;
               imm_d   = dec_imm;
               ill_d   = dec_ill;
               err_d   = 1'b0;
               rs1_d   = '0;
               rs2_d   = '0;
               cnt_d   = '0;
               state_d = (dec_nrd != 2'd0) ? RD1 : OUT;
            end
         end
         RD1, RD2: begin
            if (cu_done) begin
               if (state_q == RD1) rs1_d = cu_dataout;
               else                rs2_d = cu_dataout;
               cnt_d   = '0;
               state_d = (state_q == RD1 && nrd_q == 2'd2) ? RD2 : OUT;
            end else if (cnt_q == TO_LAST) begin
               // give up; the missing operand stays zero
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = OUT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            if (out_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         rd_q    <= '0;
         nrd_q   <= '0;
         ra1_q   <= '0;
         ra2_q   <= '0;
         imm_q   <= '0;
         ill_q   <= 1'b0;
         err_q   <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         nrd_q   <= nrd_d;
         ra1_q   <= ra1_d;
         ra2_q   <= ra2_d;
         imm_q   <= imm_d;
         ill_q   <= ill_d;
         err_q   <= err_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rvc_decode_unit.sv
// Directed bench for rvc_decode_unit: inputs driven and outputs sampled on the
// falling clock edge.
module tb_rvc_decode_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] opcode;
   logic        in_valid, in_ready;
   logic        req_data;
   logic [2:0]  addr;
   logic [1:0]  chip_sel;
   logic        cu_done;
   logic [31:0] cu_dataout;
   logic        out_valid, out_ready;
   logic [4:0]  out_op, out_rd;
   logic [31:0] out_rs1, out_rs2;
   logic [11:0] out_imm;
   logic        out_illegal, out_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rvc_decode_unit dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .in_valid(in_valid),
      .in_ready(in_ready), .req_data(req_data), .addr(addr), .chip_sel(chip_sel),
      .cu_done(cu_done), .cu_dataout(cu_dataout), .out_valid(out_valid),
      .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal),
      .out_err(out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one instruction for exactly one accept edge
   task automatic issue(input logic [15:0] op);
      opcode   = op;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      bit seen;
      rst_n = 1'b0; opcode = '0; in_valid = 1'b0; cu_done = 1'b0;
      cu_dataout = '0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req",   req_data, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_op",    out_op, 0);
      chk("rst_addr",  {chip_sel, addr}, 0);
      chk("rst_rs1",   out_rs1, 0);
      chk("rst_err",   out_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // NOP: straight to OUT, no read
      issue(16'h0001);
      chk("nop_valid", out_valid, 1);
      chk("nop_req",   req_data, 0);
      chk("nop_op",    out_op, 0);
      chk("nop_ill",   out_illegal, 0);
      chk("nop_in_ready_busy", in_ready, 0);
      @(negedge clk);
      chk("nop_back_idle", {in_ready, out_valid}, 2'b10);

      // c.addi x9,3 : one read of x9 (bank 1, index 1), done after 2 cycles
      issue(16'h048D);
      chk("addi_req",  req_data, 1);
      chk("addi_loc",  {chip_sel, addr}, {2'd1, 3'd1});
      @(negedge clk);
      chk("addi_req_hold", {req_data, chip_sel, addr}, {1'b1, 2'd1, 3'd1});
      cu_done = 1'b1; cu_dataout = 32'h11;
      @(negedge clk);
      cu_done = 1'b0;
      chk("addi_valid", out_valid, 1);
      chk("addi_req_off", req_data, 0);
      chk("addi_rs1", out_rs1, 32'h11);
      chk("addi_rs2", out_rs2, 0);
      chk("addi_imm", out_imm, 3);
      chk("addi_rd",  out_rd, 9);
      chk("addi_op",  out_op, 1);
      @(negedge clk);

      // c.sub x8,x9 : reads x8 then x9
      issue(16'h8C05);
      chk("sub_rd1_loc", {req_data, chip_sel, addr}, {1'b1, 2'd1, 3'd0});
      cu_done = 1'b1; cu_dataout = 32'hAAAA0001;
      @(negedge clk);
      cu_done = 1'b0;
      chk("sub_rd2_loc", {req_data, chip_sel, addr}, {1'b1, 2'd1, 3'd1});
      @(negedge clk);
      cu_done = 1'b1; cu_dataout = 32'h55550002;
      @(negedge clk);
      cu_done = 1'b0;
      chk("sub_op",  out_op, 9);
      chk("sub_rs1", out_rs1, 32'hAAAA0001);
      chk("sub_rs2", out_rs2, 32'h55550002);
      chk("sub_rd",  out_rd, 8);
      chk("sub_valid_noreq", {out_valid, req_data}, 2'b10);
      @(negedge clk);

      // quadrant 3 -> ILLEGAL, no read
      issue(16'h0003);
      chk("q3_ill",   {out_valid, out_illegal, req_data}, 3'b110);
      chk("q3_op",    out_op, 16);
      @(negedge clk);
      // quadrant 1 reserved register-register form
      issue(16'h9C01);
      chk("q1_resv_ill", {out_valid, out_illegal, req_data}, 3'b110);
      chk("q1_resv_op",  out_op, 16);
      @(negedge clk);
      // quadrant 0 -> UNSUP
      issue(16'h0000);
      chk("q0_unsup", {out_illegal, out_op}, {1'b1, 5'd17});
      @(negedge clk);

      // timeout with back-pressure on the result
      out_ready = 1'b0;
      issue(16'h048D);
      waited = 0;
      while (!out_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("to_cycles", waited, 15);
      chk("to_err",    out_err, 1);
      chk("to_rs1",    out_rs1, 0);
      for (int i = 0; i < 5; i++) begin
         cu_done = 1'b1; cu_dataout = 32'hDEAD0000 + i;   // must be ignored in OUT
         @(negedge clk);
         chk("bp_stable", {out_valid, in_ready, out_err, out_rd, out_imm, out_rs1},
             {1'b1, 1'b0, 1'b1, 5'd9, 12'd3, 32'd0});
      end
      cu_done = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {out_valid, in_ready}, 2'b01);

      // reset in RD1 abandons the instruction
      issue(16'h048D);
      chk("rst_rd1_req", req_data, 1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_req", {req_data, chip_sel, addr}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cu_done = (i == 2);
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      cu_done = 1'b0;
      chk("rst_no_valid", seen, 0);
      chk("rst_idle", in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
